// File: rtl/fir_stream_feeder_if.sv
// Sample stream bundle between the upstream source, the feeder and the FIR input port.
interface fir_stream_feeder_if #(
    parameter int DATA_W = 6
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] m_axis_fir_tdata;
    logic              m_axis_fir_tvalid;
    logic              m_set_coeffs;
    logic              m_axis_fir_tready;

    // Feeder side: accepts upstream samples, drives the FIR input.
    modport master (
        input  in_valid, in_data, m_axis_fir_tready,
        output in_ready, m_axis_fir_tdata, m_axis_fir_tvalid, m_set_coeffs
    );

    // Environment side: sample source plus FIR sink.
    modport slave (
        output in_valid, in_data, m_axis_fir_tready,
        input  in_ready, m_axis_fir_tdata, m_axis_fir_tvalid, m_set_coeffs
    );
endinterface

// File: rtl/fir_stream_feeder.sv
// FIR input feeder: buffers upstream samples in a small FIFO and streams them
// to the FIR, or replays the stored coefficient set as a set_coeffs burst.
//
// state | meaning
// RUN   | normal streaming, FIFO head feeds the output register
// DRAIN | burst requested, waiting for the pending sample to leave
// LOAD  | one coefficient per cycle, k = 0..NUM_COEFFS-1
module fir_stream_feeder #(
    parameter int DATA_W     = 6,
    parameter int NUM_COEFFS = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        coef_wr,
    input  logic [1:0]                  coef_idx,
    input  logic [DATA_W-1:0]           coef_data,
    input  logic                        coef_start,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    fir_stream_feeder_if.master         bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int K_W   = (NUM_COEFFS > 1) ? $clog2(NUM_COEFFS) : 1;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOAD} state_t;

    state_t             state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [DATA_W-1:0]  coef_q [NUM_COEFFS];
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q;
    logic [DATA_W-1:0]  tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               set_q, set_d;
    logic               busy_q, busy_d;
    logic               push, pop, out_free;

    assign bus.in_ready          = (level_q != LVL_W'(FIFO_DEPTH));
    assign bus.m_axis_fir_tdata  = tdata_q;
    assign bus.m_axis_fir_tvalid = tvalid_q;
    assign bus.m_set_coeffs      = set_q;
    assign busy                  = busy_q;
    assign fifo_level            = level_q;

    assign push     = bus.in_valid && bus.in_ready;
    assign out_free = !tvalid_q || bus.m_axis_fir_tready;

    // State and burst counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Next-state logic; a request is only honoured once the previous burst has fully left.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            ST_RUN: begin
                k_d = '0;
                if (coef_start && !busy_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_free) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (k_q == K_W'(NUM_COEFFS - 1)) begin
                    state_d = ST_RUN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Output-register next values; busy stays up through the last registered burst beat.
    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        set_d    = 1'b0;
        pop      = 1'b0;
        busy_d   = (state_d != ST_RUN) || (state_q == ST_LOAD);
        case (state_q)
            ST_RUN: begin
                if ((level_q != '0) && out_free) begin
                    pop      = 1'b1;
                    tdata_d  = mem_q[rd_ptr_q];
                    tvalid_d = 1'b1;
                end else if (tvalid_q && bus.m_axis_fir_tready) begin
                    tvalid_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (tvalid_q && bus.m_axis_fir_tready) tvalid_d = 1'b0;
            end
            ST_LOAD: begin
                set_d    = 1'b1;
                tdata_d  = coef_q[k_q];
                tvalid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Registered FIR-side outputs and busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            set_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            set_q    <= set_d;
            busy_q   <= busy_d;
        end
    end

    // Coefficient bank; writes are frozen while a load is pending or running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_COEFFS; i++) coef_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_COEFFS; i++) begin
                if (coef_wr && !busy_q && (int'(coef_idx) == i)) coef_q[i] <= coef_data;
            end
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.in_data;
    end
endmodule

// File: tb/tb_fir_stream_feeder.sv
module tb_fir_stream_feeder;
    localparam int DW = 6;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          coef_wr = 1'b0;
    logic [1:0]    coef_idx = '0;
    logic [DW-1:0] coef_data = '0;
    logic          coef_start = 1'b0;
    logic          busy;
    logic [2:0]    fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fir_stream_feeder_if #(.DATA_W(DW)) bus ();

    fir_stream_feeder #(.DATA_W(DW), .NUM_COEFFS(3), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .reset      (reset),
        .coef_wr    (coef_wr),
        .coef_idx   (coef_idx),
        .coef_data  (coef_data),
        .coef_start (coef_start),
        .busy       (busy),
        .fifo_level (fifo_level),
        .bus        (bus)
    );

    typedef struct packed {
        logic          iv;
        logic [DW-1:0] id;
        logic          tr;
        logic          ev;
        logic [DW-1:0] ed;
        logic [2:0]    el;
        logic          eir;
    } vec_t;

    vec_t vecs [0:15];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [DW-1:0] ed,
                             input logic es, input logic eb, input logic [2:0] el, input logic eir);
        chk({tag, " tvalid"}, 32'(bus.m_axis_fir_tvalid), 32'(ev));
        chk({tag, " tdata"}, 32'(bus.m_axis_fir_tdata), 32'(ed));
        chk({tag, " set_coeffs"}, 32'(bus.m_set_coeffs), 32'(es));
        chk({tag, " busy"}, 32'(busy), 32'(eb));
        chk({tag, " level"}, 32'(fifo_level), 32'(el));
        chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(eir));
    endtask

    task automatic write_coef(input logic [1:0] idx, input logic [DW-1:0] val);
        coef_wr = 1'b1; coef_idx = idx; coef_data = val;
        tick;
        coef_wr = 1'b0;
    endtask

    // Behavioural model state for the random phase.
    logic [DW-1:0] mq[$];
    bit            mv;
    logic [DW-1:0] md;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.m_axis_fir_tready = 1'b1;

        vecs[0]  = '{1'b1, 6'h01, 1'b1, 1'b0, 6'h00, 3'd1, 1'b1};
        vecs[1]  = '{1'b1, 6'h02, 1'b1, 1'b1, 6'h01, 3'd1, 1'b1};
        vecs[2]  = '{1'b1, 6'h03, 1'b1, 1'b1, 6'h02, 3'd1, 1'b1};
        vecs[3]  = '{1'b0, 6'h00, 1'b1, 1'b1, 6'h03, 3'd0, 1'b1};
        vecs[4]  = '{1'b0, 6'h00, 1'b1, 1'b0, 6'h03, 3'd0, 1'b1};
        vecs[5]  = '{1'b1, 6'h11, 1'b0, 1'b0, 6'h03, 3'd1, 1'b1};
        vecs[6]  = '{1'b1, 6'h12, 1'b0, 1'b1, 6'h11, 3'd1, 1'b1};
        vecs[7]  = '{1'b1, 6'h13, 1'b0, 1'b1, 6'h11, 3'd2, 1'b1};
        vecs[8]  = '{1'b1, 6'h14, 1'b0, 1'b1, 6'h11, 3'd3, 1'b1};
        vecs[9]  = '{1'b1, 6'h15, 1'b0, 1'b1, 6'h11, 3'd4, 1'b0};
        vecs[10] = '{1'b1, 6'h16, 1'b0, 1'b1, 6'h11, 3'd4, 1'b0};
        vecs[11] = '{1'b0, 6'h00, 1'b1, 1'b1, 6'h12, 3'd3, 1'b1};
        vecs[12] = '{1'b0, 6'h00, 1'b1, 1'b1, 6'h13, 3'd2, 1'b1};
        vecs[13] = '{1'b0, 6'h00, 1'b1, 1'b1, 6'h14, 3'd1, 1'b1};
        vecs[14] = '{1'b0, 6'h00, 1'b1, 1'b1, 6'h15, 3'd0, 1'b1};
        vecs[15] = '{1'b0, 6'h00, 1'b1, 1'b0, 6'h15, 3'd0, 1'b1};

        // Reset values while reset is held.
        tick; tick;
        check_out("reset", 1'b0, 6'h00, 1'b0, 1'b0, 3'd0, 1'b1);
        reset = 1'b1;

        // Streaming and backpressure vectors.
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = vecs[i].iv;
            bus.in_data = vecs[i].id;
            bus.m_axis_fir_tready = vecs[i].tr;
            tick;
            check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, 1'b0, 1'b0, vecs[i].el, vecs[i].eir);
        end
        bus.in_valid = 1'b0;
        bus.m_axis_fir_tready = 1'b1;

        // Coefficient burst, coef_start held over three edges still gives one burst.
        write_coef(2'd0, 6'h07);
        write_coef(2'd1, 6'h3B);
        write_coef(2'd2, 6'h1B);
        write_coef(2'd3, 6'h3F);
        coef_start = 1'b1;
        tick; check_out("burst n0", 1'b0, 6'h15, 1'b0, 1'b1, 3'd0, 1'b1);
        tick; check_out("burst n1", 1'b0, 6'h15, 1'b0, 1'b1, 3'd0, 1'b1);
        tick; check_out("burst n2", 1'b0, 6'h07, 1'b1, 1'b1, 3'd0, 1'b1);
        coef_start = 1'b0;
        tick; check_out("burst n3", 1'b0, 6'h3B, 1'b1, 1'b1, 3'd0, 1'b1);
        tick; check_out("burst n4", 1'b0, 6'h1B, 1'b1, 1'b1, 3'd0, 1'b1);
        tick; check_out("burst n5", 1'b0, 6'h1B, 1'b0, 1'b0, 3'd0, 1'b1);
        tick; check_out("burst n6", 1'b0, 6'h1B, 1'b0, 1'b0, 3'd0, 1'b1);

        // Load requested while a sample is stalled; coef_wr during busy is dropped.
        bus.m_axis_fir_tready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 6'h21;
        tick; check_out("pend e0", 1'b0, 6'h1B, 1'b0, 1'b0, 3'd1, 1'b1);
        bus.in_valid = 1'b0;
        tick; check_out("pend e1", 1'b1, 6'h21, 1'b0, 1'b0, 3'd0, 1'b1);
        coef_start = 1'b1;
        tick; check_out("pend e2", 1'b1, 6'h21, 1'b0, 1'b1, 3'd0, 1'b1);
        coef_start = 1'b0;
        coef_wr = 1'b1; coef_idx = 2'd0; coef_data = 6'h00;
        tick; check_out("pend e3", 1'b1, 6'h21, 1'b0, 1'b1, 3'd0, 1'b1);
        coef_wr = 1'b0;
        tick; check_out("pend e4", 1'b1, 6'h21, 1'b0, 1'b1, 3'd0, 1'b1);
        bus.m_axis_fir_tready = 1'b1;
        tick; check_out("pend e5", 1'b0, 6'h21, 1'b0, 1'b1, 3'd0, 1'b1);
        bus.in_valid = 1'b1; bus.in_data = 6'h2A;
        tick; check_out("pend e6", 1'b0, 6'h07, 1'b1, 1'b1, 3'd1, 1'b1);
        bus.in_valid = 1'b0;
        tick; check_out("pend e7", 1'b0, 6'h3B, 1'b1, 1'b1, 3'd1, 1'b1);
        tick; check_out("pend e8", 1'b0, 6'h1B, 1'b1, 1'b1, 3'd1, 1'b1);
        tick; check_out("pend e9", 1'b1, 6'h2A, 1'b0, 1'b0, 3'd0, 1'b1);
        tick; check_out("pend e10", 1'b0, 6'h2A, 1'b0, 1'b0, 3'd0, 1'b1);

        // Reset in the second LOAD cycle, then a fresh burst from cleared coefficients.
        bus.m_axis_fir_tready = 1'b0;
        coef_start = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 6'h31;
        tick; check_out("rstb n0", 1'b0, 6'h2A, 1'b0, 1'b1, 3'd1, 1'b1);
        coef_start = 1'b0;
        bus.in_data = 6'h32;
        tick; check_out("rstb n1", 1'b0, 6'h2A, 1'b0, 1'b1, 3'd2, 1'b1);
        bus.in_valid = 1'b0;
        tick; check_out("rstb n2", 1'b0, 6'h07, 1'b1, 1'b1, 3'd2, 1'b1);
        tick; check_out("rstb n3", 1'b0, 6'h3B, 1'b1, 1'b1, 3'd2, 1'b1);
        reset = 1'b0;
        #1;
        check_out("rstb async", 1'b0, 6'h00, 1'b0, 1'b0, 3'd0, 1'b1);
        tick; tick;
        reset = 1'b1;
        bus.m_axis_fir_tready = 1'b1;
        write_coef(2'd1, 6'h2C);
        coef_start = 1'b1;
        tick; check_out("rstb m0", 1'b0, 6'h00, 1'b0, 1'b1, 3'd0, 1'b1);
        coef_start = 1'b0;
        tick; check_out("rstb m1", 1'b0, 6'h00, 1'b0, 1'b1, 3'd0, 1'b1);
        tick; check_out("rstb m2", 1'b0, 6'h00, 1'b1, 1'b1, 3'd0, 1'b1);
        tick; check_out("rstb m3", 1'b0, 6'h2C, 1'b1, 1'b1, 3'd0, 1'b1);
        tick; check_out("rstb m4", 1'b0, 6'h00, 1'b1, 1'b1, 3'd0, 1'b1);
        tick; check_out("rstb m5", 1'b0, 6'h00, 1'b0, 1'b0, 3'd0, 1'b1);

        // Random streaming against a queue-based model of FIFO plus output slot.
        reset = 1'b0;
        tick;
        reset = 1'b1;
        mq.delete();
        mv = 1'b0;
        md = '0;
        for (int c = 0; c < 400; c++) begin
            logic          iv, tr, push, pop, xfer;
            logic [DW-1:0] d;
            iv = ($urandom % 4) != 0;
            tr = ($urandom % 3) != 0;
            d  = DW'($urandom);
            bus.in_valid = iv;
            bus.in_data = d;
            bus.m_axis_fir_tready = tr;
            tick;
            push = iv && (mq.size() < FD);
            pop  = (mq.size() > 0) && (!mv || tr);
            xfer = mv && tr;
            if (pop) begin
                md = mq.pop_front();
                mv = 1'b1;
            end else if (xfer) begin
                mv = 1'b0;
            end
            if (push) mq.push_back(d);
            chk($sformatf("rnd%0d tvalid", c), 32'(bus.m_axis_fir_tvalid), 32'(mv));
            if (mv) chk($sformatf("rnd%0d tdata", c), 32'(bus.m_axis_fir_tdata), 32'(md));
            chk($sformatf("rnd%0d level", c), 32'(fifo_level), 32'(mq.size()));
            chk($sformatf("rnd%0d in_ready", c), 32'(bus.in_ready), 32'(mq.size() < FD));
            chk($sformatf("rnd%0d set_coeffs", c), 32'(bus.m_set_coeffs), 32'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
